// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and constants for the LC-3 memory path.
// Bus width, access-type encodings and memory FSM states.
package lc3_pkg;

  localparam int WIDTH = 16;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

endpackage

// File: rtl/mem_access_unit_tribuf.sv
// mem_access_unit_tribuf: gated tristate buffer.
// Drives data onto bus when en=1, otherwise releases it to Z.
module mem_access_unit_tribuf #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] bus
);

  assign bus = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR endpoint with req/ack memory handshake.
// Emits the one-cycle ready pulse (err on timeout) to the control FSM.
module mem_access_unit #(
  parameter int WIDTH          = lc3_pkg::WIDTH,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic             gate_mdr,
  output logic [WIDTH-1:0] mdr_to_bus,
  output logic             ready,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);
  import lc3_pkg::*;

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  stateT            state;
  stateT            nextState;
  logic [WIDTH-1:0] mar;
  logic [WIDTH-1:0] mdr;
  logic             weQ;
  logic             errQ;
  logic [CNT_W-1:0] cnt;
  logic             idle;
  logic             busy;
  logic             start;
  logic             timeoutHit;

  assign idle  = state == IDLE;
  assign busy  = state == BUSY;
  assign start = idle && mio_en;

  // cnt holds the no-ack cycles already spent, so the limit
  // is hit on the cycle that would make it TIMEOUT_CYCLES
  assign timeoutHit = TO_EN && busy && !mem_ack &&
                      cnt == LIMIT;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (mio_en) nextState = BUSY;
      BUSY:    if (mem_ack || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      weQ   <= R_W_READ;
      errQ  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (idle && ld_mar) mar <= bus_in;
      unique case (1'b1)
        idle && ld_mdr && !mio_en:
          mdr <= bus_in;
        busy && mem_ack && weQ == R_W_READ:
          mdr <= mem_rdata;
        default: ;
      endcase
      if (start) weQ <= r_w;
      if (start) begin
        cnt <= '0;
      end else if (TO_EN && busy && !mem_ack &&
                   cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (busy) errQ <= timeoutHit;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy && weQ == R_W_WRITE;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign ready     = state == DONE;
  assign err       = state == DONE && errQ;

  mem_access_unit_tribuf #(
    .WIDTH (WIDTH)
  ) uBuf (
    .data (mdr),
    .en   (gate_mdr),
    .bus  (mdr_to_bus)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: two instances (default and 4-cycle timeout)
// checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] busIn;
  logic [15:0] memRdata;
  logic        ldMar;
  logic        ldMdr;
  logic        rW;
  logic        gateMdr;
  logic        memAck;
  logic        mioEn    [2];
  logic        ready    [2];
  logic        err      [2];
  logic        memReq   [2];
  logic        memWe    [2];
  logic [15:0] memAddr  [2];
  logic [15:0] memWdata [2];
  wire  [15:0] busOut0;
  wire  [15:0] busOut1;

  mem_access_unit u0 (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (busIn),
    .ld_mar     (ldMar),
    .ld_mdr     (ldMdr),
    .mio_en     (mioEn[0]),
    .r_w        (rW),
    .gate_mdr   (gateMdr),
    .mdr_to_bus (busOut0),
    .ready      (ready[0]),
    .err        (err[0]),
    .mem_req    (memReq[0]),
    .mem_we     (memWe[0]),
    .mem_addr   (memAddr[0]),
    .mem_wdata  (memWdata[0]),
    .mem_rdata  (memRdata),
    .mem_ack    (memAck)
  );

  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (3)
  ) u1 (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (busIn),
    .ld_mar     (ldMar),
    .ld_mdr     (ldMdr),
    .mio_en     (mioEn[1]),
    .r_w        (rW),
    .gate_mdr   (gateMdr),
    .mdr_to_bus (busOut1),
    .ready      (ready[1]),
    .err        (err[1]),
    .mem_req    (memReq[1]),
    .mem_we     (memWe[1]),
    .mem_addr   (memAddr[1]),
    .mem_wdata  (memWdata[1]),
    .mem_rdata  (memRdata),
    .mem_ack    (memAck)
  );

  int nChecks = 0;
  int nFail   = 0;
  bit checkOn = 1'b0;
  int readyCnt [2] = '{0, 0};

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s[%0d]: got %h, expected %h",
               name, idx, got, exp);
    end
  endtask

  task automatic chkNe(input string name, input int idx,
                       input logic [15:0] got,
                       input logic [15:0] notExp);
    nChecks++;
    if (got === notExp) begin
      nFail++;
      $display("FAIL %s[%0d]: got %h, expected Z (not %h)",
               name, idx, got, notExp);
    end
  endtask

  function automatic int limOf(input int i);
    return (i == 0) ? 255 : 4;
  endfunction

  // Transaction model: an access is "active" until acked or it has
  // waited the limit; completion shows as ready the following cycle.
  logic [15:0] marM [2];
  logic [15:0] mdrM [2];
  bit          weM  [2];
  bit          actM [2];
  bit          finM [2];
  bit          errM [2];
  int          wait_[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [15:0] ma;
      logic [15:0] md;
      bit we;
      bit ac;
      bit fi;
      bit er;
      int w;
      ma = marM[i]; md = mdrM[i]; we = weM[i];
      ac = actM[i]; fi = finM[i]; er = errM[i];
      w = wait_[i];
      if (rst) begin
        ma = 0; md = 0; we = 0;
        ac = 0; fi = 0; er = 0; w = 0;
      end else if (fi) begin
        fi = 0; er = 0;
      end else if (ac) begin
        if (memAck) begin
          if (!we) md = memRdata;
          ac = 0; fi = 1; er = 0;
        end else begin
          w = w + 1;
          if (w == limOf(i)) begin
            ac = 0; fi = 1; er = 1;
          end
        end
      end else begin
        if (ldMar) ma = busIn;
        if (ldMdr && !mioEn[i]) md = busIn;
        if (mioEn[i]) begin
          we = rW; w = 0; ac = 1;
        end
      end
      marM[i] <= ma; mdrM[i] <= md; weM[i] <= we;
      actM[i] <= ac; finM[i] <= fi; errM[i] <= er;
      wait_[i] <= w;
    end
  end

  always @(posedge clk) begin
    #1;
    if (checkOn) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] b;
        b = (i == 0) ? busOut0 : busOut1;
        chk("memReq", i, memReq[i], actM[i]);
        chk("memWe", i, memWe[i], actM[i] && weM[i]);
        chk("memAddr", i, memAddr[i], marM[i]);
        chk("memWdata", i, memWdata[i], mdrM[i]);
        chk("ready", i, ready[i], finM[i]);
        chk("err", i, err[i], finM[i] && errM[i]);
        if (gateMdr) chk("busOn", i, b, mdrM[i]);
        else if (mdrM[i] != 0) chkNe("busOff", i, b, mdrM[i]);
        if (ready[i] === 1'b1) readyCnt[i]++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0;
    int firstReady;
    int rise2;
    int nReady;
    logic prevReq;
    rst = 1; busIn = 0; memRdata = 0; ldMar = 0;
    ldMdr = 0; rW = 0; gateMdr = 0; memAck = 0;
    mioEn[0] = 0; mioEn[1] = 0;
    step(2);
    rst = 0;
    checkOn = 1;
    chk("rstReq", 0, memReq[0], 0);
    chk("rstAddr", 0, memAddr[0], 16'h0000);
    chk("rstMdr", 0, memWdata[0], 16'h0000);
    chk("rstReady", 0, ready[0], 0);
    gateMdr = 1; #1;
    chk("rstBus", 0, busOut0, 16'h0000);
    gateMdr = 0;

    // write 3000 <- BEEF, ack in first request cycle
    busIn = 16'h3000; ldMar = 1; step();
    busIn = 16'hBEEF; ldMar = 0; ldMdr = 1; step();
    ldMdr = 0;
    chkNe("gateOff", 0, busOut0, 16'hBEEF);
    mioEn[0] = 1; rW = 1; memAck = 1; step();
    chk("wrReq", 0, memReq[0], 1);
    chk("wrWe", 0, memWe[0], 1);
    chk("wrAddr", 0, memAddr[0], 16'h3000);
    chk("wrData", 0, memWdata[0], 16'hBEEF);
    mioEn[0] = 0; step();
    chk("wrReady", 0, ready[0], 1);
    chk("wrErr", 0, err[0], 0);
    memAck = 0; step();

    // clear MDR, then read it back from memory
    ldMdr = 1; busIn = 16'h0000; step();
    ldMdr = 0; mioEn[0] = 1; rW = 0;
    memRdata = 16'hBEEF; memAck = 1; step();
    chk("rdReq", 0, memReq[0], 1);
    chk("rdWe", 0, memWe[0], 0);
    mioEn[0] = 0; step();
    chk("rdReady", 0, ready[0], 1);
    memAck = 0; gateMdr = 1; #1;
    chk("rdBus", 0, busOut0, 16'hBEEF);
    step(); gateMdr = 0;

    // delayed ack after 5 cycles, loads ignored while busy
    mioEn[0] = 1; rW = 0; memRdata = 16'h1234;
    r0 = readyCnt[0]; step();
    mioEn[0] = 0;
    for (int k = 1; k <= 5; k++) begin
      chk("dlyReq", k, memReq[0], 1);
      chk("dlyAddr", k, memAddr[0], 16'h3000);
      chk("dlyMdr", k, memWdata[0], 16'hBEEF);
      chk("dlyReady", k, ready[0], 0);
      if (k == 2) begin
        ldMar = 1; ldMdr = 1; busIn = 16'hFFFF;
      end
      if (k == 3) begin
        ldMar = 0; ldMdr = 0;
      end
      if (k == 5) memAck = 1;
      step();
    end
    chk("dlyDone", 0, ready[0], 1);
    chk("dlyErr", 0, err[0], 0);
    chk("dlyData", 0, memWdata[0], 16'h1234);
    chk("modelMdr", 0, mdrM[0], 16'h1234);
    memAck = 0; step();
    chk("dlyAddrAfter", 0, memAddr[0], 16'h3000);
    chk("dlyOnce", 0, readyCnt[0] - r0, 1);

    // timeout on u1 after 4 unacked cycles
    mioEn[1] = 1; rW = 0; step();
    mioEn[1] = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("toReq", k, memReq[1], 1);
      chk("toReady", k, ready[1], 0);
      step();
    end
    chk("toDone", 1, ready[1], 1);
    chk("toErr", 1, err[1], 1);
    chk("toReqOff", 1, memReq[1], 0);
    chk("toMdr", 1, memWdata[1], 16'hFFFF);
    step();
    chk("toReady2", 1, ready[1], 0);

    // ack on the limit cycle wins
    memRdata = 16'h5A5A; mioEn[1] = 1; step();
    mioEn[1] = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) memAck = 1;
      step();
    end
    chk("limDone", 1, ready[1], 1);
    chk("limErr", 1, err[1], 0);
    chk("limData", 1, memWdata[1], 16'h5A5A);
    memAck = 0; step();

    // reset in the middle of a request
    mioEn[0] = 1; rW = 1; step();
    mioEn[0] = 0; step();
    chk("rbReq", 0, memReq[0], 1);
    r0 = readyCnt[0];
    rst = 1; step();
    chk("rbReqOff", 0, memReq[0], 0);
    chk("rbMar", 0, memAddr[0], 16'h0000);
    chk("rbMdr", 0, memWdata[0], 16'h0000);
    rst = 0; step(3);
    chk("rbNoReady", 0, readyCnt[0] - r0, 0);
    gateMdr = 1; #1;
    chk("rbBus", 0, busOut0, 16'h0000);
    gateMdr = 0;

    // mio_en held across DONE: two back-to-back writes
    busIn = 16'h4000; ldMar = 1; step();
    ldMar = 0; mioEn[0] = 1; rW = 1; memAck = 1;
    firstReady = -1; rise2 = -1; nReady = 0; prevReq = 0;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (ready[0] === 1'b1) begin
        nReady++;
        if (firstReady < 0) firstReady = j;
      end
      if (memReq[0] === 1'b1 && !prevReq &&
          firstReady >= 0 && rise2 < 0) rise2 = j;
      prevReq = memReq[0];
      if (j == 4) mioEn[0] = 0;
    end
    memAck = 0;
    chk("b2bReadies", 0, nReady, 2);
    chk("b2bFirst", 0, firstReady, 2);
    chk("b2bGap", 0, rise2 - firstReady, 2);
    chk("b2bAddr", 0, memAddr[0], 16'h4000);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
